// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter with r1 lock bursts and 1-cycle read response
// Optional round-robin tie-break: define DMEM_ARB_RR_EN (default build is fixed priority, r0 wins ties).
module dmem_arbiter #(
  parameter int ADRS_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LOCK_MAX   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    r0_valid_i,
  output logic                    r0_ready_o,
  input  logic [ADRS_WIDTH-1:0]   r0_adrs_i,
  input  logic                    r0_wren_i,
  input  logic [WORD_WIDTH/8-1:0] r0_byt_en_i,
  input  logic [WORD_WIDTH-1:0]   r0_wr_data_i,
  output logic                    r0_rsp_valid_o,
  output logic [WORD_WIDTH-1:0]   r0_rd_data_o,

  input  logic                    r1_valid_i,
  output logic                    r1_ready_o,
  input  logic [ADRS_WIDTH-1:0]   r1_adrs_i,
  input  logic                    r1_wren_i,
  input  logic [WORD_WIDTH/8-1:0] r1_byt_en_i,
  input  logic [WORD_WIDTH-1:0]   r1_wr_data_i,
  output logic                    r1_rsp_valid_o,
  output logic [WORD_WIDTH-1:0]   r1_rd_data_o,
  input  logic                    r1_lock_i,

  output logic [ADRS_WIDTH-1:0]   m_adrs_o,
  output logic                    m_rden_o,
  output logic                    m_wren_o,
  output logic [WORD_WIDTH/8-1:0] m_byt_en_o,
  output logic [WORD_WIDTH-1:0]   m_wr_data_o,
  input  logic [WORD_WIDTH-1:0]   m_rd_data_i
);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

  lock_state_e           state_q;
  logic [7:0]            lock_cnt_q;
  logic                  force_r0_q;
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [WORD_WIDTH-1:0] rsp_data_q;
`ifdef DMEM_ARB_RR_EN
  logic                  last_grant_q;
`endif

  logic lock_owner;
  logic gnt0;
  logic gnt1;
  logic any_gnt;
  logic sel_wren;

  assign lock_owner = (state_q == LOCKED);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (lock_owner && r1_valid_i) begin
        gnt1 = 1'b1;
      end else if (r0_valid_i && r1_valid_i) begin
        if (force_r0_q) begin
          gnt0 = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
          gnt0 = last_grant_q;
          gnt1 = !last_grant_q;
`else
          gnt0 = 1'b1;
`endif
        end
      end else begin
        gnt0 = r0_valid_i;
        gnt1 = r1_valid_i;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign sel_wren   = gnt1 ? r1_wren_i : r0_wren_i;
  assign r0_ready_o = gnt0;
  assign r1_ready_o = gnt1;

  // Idle port drives zeros so the memory never sees a stale address.
  assign m_rden_o    = any_gnt & ~sel_wren;
  assign m_wren_o    = any_gnt &  sel_wren;
  assign m_adrs_o    = gnt1 ? r1_adrs_i    : (gnt0 ? r0_adrs_i    : '0);
  assign m_byt_en_o  = gnt1 ? r1_byt_en_i  : (gnt0 ? r0_byt_en_i  : '0);
  assign m_wr_data_o = gnt1 ? r1_wr_data_i : (gnt0 ? r0_wr_data_i : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= 8'd0;
      force_r0_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      force_r0_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      if (any_gnt) last_grant_q <= gnt1;
`endif
      case (state_q)
        UNLOCKED: begin
          if (gnt1 && r1_lock_i && (LOCK_MAX > 1)) begin
            state_q    <= LOCKED;
            lock_cnt_q <= 8'd1;
          end
        end
        LOCKED: begin
          // While locked, a missing r1 grant can only mean r1_valid dropped.
          if (!gnt1 || !r1_lock_i) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= 8'd0;
          end else if (({1'b0, lock_cnt_q} + 9'd1) >= LOCK_LIMIT) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= 8'd0;
            force_r0_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= UNLOCKED;
          lock_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= m_rden_o;
      rsp_id_q    <= gnt1;
      rsp_data_q  <= m_rden_o ? m_rd_data_i : '0;
    end
  end

  assign r0_rsp_valid_o = rsp_valid_q & ~rsp_id_q;
  assign r1_rsp_valid_o = rsp_valid_q &  rsp_id_q;
  assign r0_rd_data_o   = r0_rsp_valid_o ? rsp_data_q : '0;
  assign r1_rd_data_o   = r1_rsp_valid_o ? rsp_data_q : '0;

endmodule
